// File: rtl/asmodee_boot_seq_if.sv
// Boot sequencer bus: the launch request and mask from the SoC side,
// plus the per-core control lines and status flags back from the sequencer.
interface asmodee_boot_seq_if #(
  parameter int N_CORES = 1
);
  logic               go_i;
  logic [N_CORES-1:0] en_mask_i;
  logic [N_CORES-1:0] core_rst_o;
  logic [N_CORES-1:0] core_boot_o;
  logic [N_CORES-1:0] core_start_o;
  logic               busy_o;
  logic               done_o;

  // SoC side: issues launch requests and observes the core lines
  modport master (
    output go_i, en_mask_i,
    input  core_rst_o, core_boot_o, core_start_o, busy_o, done_o
  );

  // Sequencer side
  modport slave (
    input  go_i, en_mask_i,
    output core_rst_o, core_boot_o, core_start_o, busy_o, done_o
  );
endinterface

// File: rtl/asmodee_boot_seq.sv
// Boot sequencer for Asmodee asynchronous cores: reset hold, boot-address
// load, release, then one (optionally staggered) start pulse per enabled core.
// All core-facing outputs and status flags come straight from flops.
module asmodee_boot_seq #(
  parameter int N_CORES   = 1,
  parameter int RST_CYC   = 10,
  parameter int BOOT_CYC  = 5,
  parameter int START_DLY = 5,
  parameter int START_CYC = 1,
  parameter int STAGGER   = 0,
  parameter bit AUTO_BOOT = 1'b1
) (
  input logic              clk_i,
  input logic              rst_ni,
  asmodee_boot_seq_if.slave bus
);

  // Longest START phase: every core enabled, each one STAGGER after the last.
  localparam int START_MAX = (N_CORES - 1) * STAGGER + START_CYC;
  localparam int MAX_A     = (RST_CYC > BOOT_CYC) ? RST_CYC : BOOT_CYC;
  localparam int MAX_B     = (START_DLY > START_MAX) ? START_DLY : START_MAX;
  localparam int MAX_CNT   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW        = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    BOOT,
    GAP,
    START,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_CORES-1:0] mask_q, mask_d;
  logic [N_CORES-1:0] core_rst_q, core_rst_d;
  logic [N_CORES-1:0] core_boot_q, core_boot_d;
  logic [N_CORES-1:0] core_start_q, core_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               launch;
  int                 rise_at [N_CORES];
  int                 start_total;
  int                 start_elapsed;
  int                 n_en;

  // Rise offset of each enabled core within START, and the START phase length.
  always_comb begin
    n_en = 0;
    for (int j = 0; j < N_CORES; j++) begin
      rise_at[j] = n_en * STAGGER;
      if (mask_q[j]) n_en = n_en + 1;
    end
    start_total = (n_en == 0) ? START_CYC : (n_en - 1) * STAGGER + START_CYC;
  end

  // Phase sequencing; a launch (go or auto-boot from IDLE) overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    launch  = bus.go_i || (AUTO_BOOT && (state_q == IDLE));
    if (launch) begin
      state_d = RST_HOLD;
      cnt_d   = CW'(RST_CYC - 1);
      mask_d  = bus.en_mask_i;
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = BOOT;
            cnt_d   = CW'(BOOT_CYC - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        BOOT: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = CW'(START_DLY - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_d = START;
            cnt_d   = CW'(start_total - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        START: begin
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next output values derived from the upcoming state so they can be registered.
  always_comb begin
    core_rst_d    = '1;
    core_boot_d   = '0;
    core_start_d  = '0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    start_elapsed = start_total - 1 - int'(cnt_d);
    case (state_d)
      RST_HOLD: busy_d = 1'b1;
      BOOT: begin
        busy_d      = 1'b1;
        core_boot_d = mask_d;
      end
      GAP: begin
        busy_d     = 1'b1;
        core_rst_d = ~mask_d;
      end
      START: begin
        busy_d     = 1'b1;
        core_rst_d = ~mask_d;
        for (int j = 0; j < N_CORES; j++) begin
          core_start_d[j] = mask_d[j] && (start_elapsed >= rise_at[j]) &&
                            (start_elapsed < rise_at[j] + START_CYC);
        end
      end
      RUN: begin
        done_d     = 1'b1;
        core_rst_d = ~mask_d;
      end
      default: ;
    endcase
  end

  // State, counter, latched mask and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      core_rst_q   <= '1;
      core_boot_q  <= '0;
      core_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      core_rst_q   <= core_rst_d;
      core_boot_q  <= core_boot_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.core_rst_o   = core_rst_q;
  assign bus.core_boot_o  = core_boot_q;
  assign bus.core_start_o = core_start_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_asmodee_boot_seq.sv
// Bench for asmodee_boot_seq: two sequencers with different timing (one
// auto-booting, one go-only) driven with directed and random launches, aborts
// and async resets, compared every cycle against a cycle-offset model.
module tb_asmodee_boot_seq;

  // Sequencer A: four cores, auto-boot, staggered non-overlapping pulses
  localparam int A_N = 4, A_R = 10, A_B = 5, A_D = 5, A_W = 2, A_ST = 3;
  // Sequencer B: three cores, go-only, overlapping pulses
  localparam int B_N = 3, B_R = 3, B_B = 2, B_D = 2, B_W = 4, B_ST = 2;

  typedef struct {
    logic [7:0] rst;
    logic [7:0] boot;
    logic [7:0] start;
    logic [7:0] busy;
    logic [7:0] done;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int         nA = 0, nB = 0;
  bit         launchedA = 1'b0, launchedB = 1'b0;
  logic [7:0] maskA = '0, maskB = '0;

  asmodee_boot_seq_if #(.N_CORES(A_N)) ifA ();
  asmodee_boot_seq_if #(.N_CORES(B_N)) ifB ();

  asmodee_boot_seq #(
    .N_CORES(A_N), .RST_CYC(A_R), .BOOT_CYC(A_B), .START_DLY(A_D),
    .START_CYC(A_W), .STAGGER(A_ST), .AUTO_BOOT(1'b1)
  ) uA (
    .clk_i(clk), .rst_ni(rstN), .bus(ifA)
  );

  asmodee_boot_seq #(
    .N_CORES(B_N), .RST_CYC(B_R), .BOOT_CYC(B_B), .START_DLY(B_D),
    .START_CYC(B_W), .STAGGER(B_ST), .AUTO_BOOT(1'b0)
  ) uB (
    .clk_i(clk), .rst_ni(rstN), .bus(ifB)
  );

  always #5 clk = ~clk;

  // Expected outputs n cycles after a launch edge (n=1 is the first RST_HOLD cycle).
  function automatic exp_t modelOut(input int n, input logic [7:0] mask, input int nc,
                                    input int r, input int b, input int d,
                                    input int w, input int st, input bit launched);
    exp_t       e;
    logic [7:0] all;
    int         s0, nextRise, endCyc;
    all     = 8'((1 << nc) - 1);
    e.rst   = all;
    e.boot  = '0;
    e.start = '0;
    e.busy  = '0;
    e.done  = '0;
    if (!launched) return e;
    s0       = r + b + d + 1;
    endCyc   = s0 + w - 1;
    nextRise = s0;
    for (int j = 0; j < nc; j++) begin
      if (mask[j]) begin
        if (n >= nextRise && n < nextRise + w) e.start[j] = 1'b1;
        if (nextRise + w - 1 > endCyc) endCyc = nextRise + w - 1;
        nextRise = nextRise + st;
      end
    end
    if (n <= r) begin
      e.busy = 8'd1;
    end else if (n <= r + b) begin
      e.busy = 8'd1;
      e.boot = mask & all;
    end else if (n <= endCyc) begin
      e.busy = 8'd1;
      e.rst  = ~mask & all;
    end else begin
      e.done = 8'd1;
      e.rst  = ~mask & all;
    end
    return e;
  endfunction

  task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both sequencers against the model.
  task automatic checkOutput();
    exp_t eA, eB;
    eA = modelOut(nA, maskA, A_N, A_R, A_B, A_D, A_W, A_ST, launchedA);
    eB = modelOut(nB, maskB, B_N, B_R, B_B, B_D, B_W, B_ST, launchedB);
    checkOne("A.rst",   8'(ifA.core_rst_o),   eA.rst);
    checkOne("A.boot",  8'(ifA.core_boot_o),  eA.boot);
    checkOne("A.start", 8'(ifA.core_start_o), eA.start);
    checkOne("A.busy",  8'(ifA.busy_o),       eA.busy);
    checkOne("A.done",  8'(ifA.done_o),       eA.done);
    checkOne("B.rst",   8'(ifB.core_rst_o),   eB.rst);
    checkOne("B.boot",  8'(ifB.core_boot_o),  eB.boot);
    checkOne("B.start", 8'(ifB.core_start_o), eB.start);
    checkOne("B.busy",  8'(ifB.busy_o),       eB.busy);
    checkOne("B.done",  8'(ifB.done_o),       eB.done);
  endtask

  // One clock: advance the model trackers from the inputs seen at the edge, then check.
  task automatic stepCycle();
    @(posedge clk);
    if (rstN) begin
      if (ifA.go_i || !launchedA) begin
        launchedA = 1'b1;
        nA        = 1;
        maskA     = 8'(ifA.en_mask_i);
      end else begin
        nA++;
      end
      if (ifB.go_i) begin
        launchedB = 1'b1;
        nB        = 1;
        maskB     = 8'(ifB.en_mask_i);
      end else if (launchedB) begin
        nB++;
      end
    end
    #1;
    checkOutput();
  endtask

  // Present go/mask to both sequencers for one edge, then drop go.
  task automatic applyStimulus(input logic goA, input logic [A_N-1:0] mA,
                               input logic goB, input logic [B_N-1:0] mB);
    ifA.go_i      = goA;
    ifA.en_mask_i = mA;
    ifB.go_i      = goB;
    ifB.en_mask_i = mB;
    stepCycle();
    ifA.go_i = 1'b0;
    ifB.go_i = 1'b0;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    ifA.go_i      = 1'b0;
    ifA.en_mask_i = 4'b1011;
    ifB.go_i      = 1'b0;
    ifB.en_mask_i = 3'b101;

    // Reset values while rst_ni is held low
    runCycles(2);

    // A auto-boots with mask 1011 (staggered 0,1,3); B stays idle without go
    releaseReset();
    runCycles(40);

    // B normal launch, overlapping pulses on cores 0 and 1
    applyStimulus(1'b0, 4'b1011, 1'b1, 3'b011);
    runCycles(25);

    // A relaunched from RUN with an empty mask: full timing, no pulses
    applyStimulus(1'b1, 4'b0000, 1'b0, 3'b011);
    runCycles(30);

    // A aborted mid-BOOT, B aborted mid-START
    applyStimulus(1'b1, 4'b1111, 1'b1, 3'b111);
    runCycles(10);
    applyStimulus(1'b1, 4'b0110, 1'b0, 3'b111);
    runCycles(3);
    applyStimulus(1'b0, 4'b0110, 1'b1, 3'b110);
    runCycles(35);

    // Async reset while B has start pulses active
    applyStimulus(1'b0, 4'b0110, 1'b1, 3'b111);
    runCycles(8);
    #2;
    rstN      = 1'b0;
    launchedA = 1'b0;
    launchedB = 1'b0;
    #1;
    checkOutput();
    runCycles(3);
    ifA.en_mask_i = 4'b1001;
    releaseReset();
    runCycles(12);
    applyStimulus(1'b0, 4'b1001, 1'b1, 3'b100);
    runCycles(20);

    // Random launches, aborts and masks
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 24) == 0), 4'($urandom),
                    ($urandom_range(0, 17) == 0), 3'($urandom));
    end

    $display("[TB] random phase complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
